key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The module SHALL have parameter N_KEYS, default 4, meaning the number of independent key channels.
REQ-002 The module SHALL have parameter DEB_CYCLES, default 1_000_000, meaning the consecutive stable samples required to accept a level change (20 ms at 50 MHz).
REQ-003 The module SHALL have parameter LONG_CYCLES, default 50_000_000, meaning the accepted-press duration before a long-press event (1 s).
REQ-004 The module SHALL have parameter REPEAT_CYCLES, default 10_000_000, meaning the auto-repeat period after a long press (200 ms).
REQ-005 The module SHALL have port clkI, input, width 1: the single system clock; all logic is clocked on its rising edge.
REQ-006 The module SHALL have port rstnI, input, width 1: asynchronous, active-low reset.
REQ-007 The module SHALL have port keyI, input, width N_KEYS: raw board keys, asynchronous, active-low (0 = pressed).
REQ-008 The module SHALL have port levelO, output, width N_KEYS: debounced key state, active-high (1 = pressed).
REQ-009 The module SHALL have port pressO, output, width N_KEYS: one-cycle pulse per accepted press.
REQ-010 The module SHALL have port releaseO, output, width N_KEYS: one-cycle pulse per accepted release.
REQ-011 The module SHALL have port longO, output, width N_KEYS: one-cycle pulse when a press reaches LONG_CYCLES.
REQ-012 The module SHALL have port repeatO, output, width N_KEYS: one-cycle pulse every REPEAT_CYCLES while a long press is held.

Function
REQ-013 Each keyI bit SHALL pass through a 2-flop synchronizer, then invert; all later logic SHALL use only the synchronized, active-high sample s.
REQ-014 Each channel SHALL run an independent FSM with states IDLE, DEB_PRESS, PRESSED, LONG, DEB_RELEASE, plus one debounce counter and one hold counter, each wide enough for its largest parameter.
REQ-015 IDLE: when s=1, the FSM SHALL go to DEB_PRESS with the debounce counter cleared; otherwise it stays.
REQ-016 DEB_PRESS: s=1 SHALL increment the debounce counter; s=0 SHALL return to IDLE with no output; on the count reaching DEB_CYCLES, the FSM SHALL go to PRESSED, set levelO=1, pulse pressO, and clear the hold counter.
REQ-017 Latency: with keyI held low from sampling edge 0, pressO SHALL be high during exactly the one cycle following edge 2+DEB_CYCLES, and levelO SHALL rise in that same cycle.
REQ-018 PRESSED: the hold counter SHALL increment each cycle; on reaching LONG_CYCLES, the FSM SHALL pulse longO, clear the hold counter, and go to LONG.
REQ-019 LONG: the hold counter SHALL increment each cycle; on reaching REPEAT_CYCLES, the FSM SHALL pulse repeatO, clear the counter, and wrap; the first repeatO SHALL occur REPEAT_CYCLES cycles after longO.
REQ-020 PRESSED/LONG with s=0: the FSM SHALL go to DEB_RELEASE, remember the origin state, and freeze the hold counter.
REQ-021 DEB_RELEASE: s=0 stable for DEB_CYCLES SHALL go to IDLE, clear levelO, and pulse releaseO; s=1 before then SHALL return to the origin state, resume the hold counter, and produce no pulse.
REQ-022 At most one of pressO/releaseO/longO/repeatO SHALL be high per channel per cycle; the channels SHALL be fully independent, and simultaneous events on different keys SHALL all be reported in the same cycle.
REQ-023 Counters SHALL saturate or clear as specified and SHALL never wrap silently; repeatO SHALL continue indefinitely while the key is held.
REQ-024 Bounce shorter than DEB_CYCLES in any debounce state SHALL produce no pulse and no levelO change.

Reset
REQ-025 While rstnI=0, all FSMs SHALL be IDLE, all counters and synchronizer flops SHALL be 0 (not pressed), and levelO, pressO, releaseO, longO and repeatO SHALL be 0.
REQ-026 Reset asserted mid-press SHALL drop levelO immediately with no releaseO; after deassertion with the key still held, a fresh DEB_CYCLES debounce SHALL precede any pressO.

Verification (sim parameters DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
REQ-027 keyI[0] low from edge 0 -> pressO[0] high in the single cycle after edge 6 and levelO[0]=1; other bits stay 0.
REQ-028 keyI[1] low for 3 cycles, then high -> no pulses and levelO[1] stays 0.
REQ-029 keyI[2] held low 40 cycles after acceptance -> longO[2] at hold count 20, then repeatO[2] at +5, +10, +15, +20.
REQ-030 Held key with a 2-cycle high glitch -> no releaseO, the hold count resumes, and longO timing shifts by only the frozen cycles; a release stable for 4 cycles -> one releaseO and levelO=0.
REQ-031 keyI[0] and keyI[3] pressed on the same edge -> pressO=4'b1001 in one cycle.
REQ-032 rstnI pulsed low while levelO[1]=1 -> levelO[1]=0 asynchronously, no releaseO, and re-press accepted DEB_CYCLES+2 after release of reset.

Source files
------------

// File: rtl/key_conditioner.sv
// Debounces N active-low board keys and turns them into level, press/release, long-press and auto-repeat events.
// Latency: pressO and levelO are registered and appear DEB_CYCLES+2 edges after keyI first reads low.
// Backpressure: none; every event is a free-running one-cycle pulse.
module key_conditioner #(
    parameter int N_KEYS        = 4,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic              clkI,
    input  logic              rstnI,
    input  logic [N_KEYS-1:0] keyI,
    output logic [N_KEYS-1:0] levelO,
    output logic [N_KEYS-1:0] pressO,
    output logic [N_KEYS-1:0] releaseO,
    output logic [N_KEYS-1:0] longO,
    output logic [N_KEYS-1:0] repeatO
);

    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DEB_PRESS = 3'd1;
    localparam logic [2:0] ST_PRESSED   = 3'd2;
    localparam logic [2:0] ST_LONG      = 3'd3;
    localparam logic [2:0] ST_DEB_REL   = 3'd4;

    // Inverted on entry so that a cleared synchronizer already means "not pressed".
    logic [N_KEYS-1:0] meta_q, meta_d;
    logic [N_KEYS-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = ~keyI;
        sync_d = meta_q;
    end

    always_ff @(posedge clkI or negedge rstnI) begin
        if (!rstnI) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic              s;
        logic [2:0]        state_q, state_d;
        logic [DEB_W-1:0]  deb_q, deb_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              origin_long_q, origin_long_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              long_q, long_d;
        logic              repeat_q, repeat_d;
        logic              held;
        logic              in_long;

        assign s = sync_q[g];

        always_comb begin
            state_d       = state_q;
            deb_d         = deb_q;
            hold_d        = hold_q;
            origin_long_d = origin_long_q;
            level_d       = level_q;
            press_d       = 1'b0;
            release_d     = 1'b0;
            long_d        = 1'b0;
            repeat_d      = 1'b0;
            held          = 1'b0;
            in_long       = (state_q == ST_LONG) ||
                            ((state_q == ST_DEB_REL) && origin_long_q);

            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        state_d = ST_DEB_PRESS;
                        deb_d   = '0;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!s) begin
                        state_d = ST_IDLE;
                    end else if (deb_q == DEB_LAST) begin
                        state_d = ST_PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end
                ST_PRESSED, ST_LONG: begin
                    if (!s) begin
                        state_d       = ST_DEB_REL;
                        origin_long_d = (state_q == ST_LONG);
                        deb_d         = '0;
                    end else begin
                        held = 1'b1;
                    end
                end
                ST_DEB_REL: begin
                    if (s) begin
                        held = 1'b1;
                    end else if (deb_q == DEB_LAST) begin
                        state_d   = ST_IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                end
            endcase

            // A bounce that recovers counts as a held sample, so only the low samples are lost.
            if (held) begin
                state_d = in_long ? ST_LONG : ST_PRESSED;
                if (in_long && (hold_q == REPEAT_LAST)) begin
                    repeat_d = 1'b1;
                    hold_d   = '0;
                end else if (!in_long && (hold_q == LONG_LAST)) begin
                    long_d  = 1'b1;
                    hold_d  = '0;
                    state_d = ST_LONG;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        end

        always_ff @(posedge clkI or negedge rstnI) begin
            if (!rstnI) begin
                state_q       <= ST_IDLE;
                deb_q         <= '0;
                hold_q        <= '0;
                origin_long_q <= 1'b0;
                level_q       <= 1'b0;
                press_q       <= 1'b0;
                release_q     <= 1'b0;
                long_q        <= 1'b0;
                repeat_q      <= 1'b0;
            end else begin
                state_q       <= state_d;
                deb_q         <= deb_d;
                hold_q        <= hold_d;
                origin_long_q <= origin_long_d;
                level_q       <= level_d;
                press_q       <= press_d;
                release_q     <= release_d;
                long_q        <= long_d;
                repeat_q      <= repeat_d;
            end
        end

        assign levelO[g]   = level_q;
        assign pressO[g]   = press_q;
        assign releaseO[g] = release_q;
        assign longO[g]    = long_q;
        assign repeatO[g]  = repeat_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/long/repeat periods.
// Edge 0 is the first rising edge after keyI changes; checks sample #1 after each edge.
module tb_key_conditioner;

    logic       clkI;
    logic       rstnI;
    logic [3:0] keyI;
    logic [3:0] levelO, pressO, releaseO, longO, repeatO;

    int n_vec  = 0;
    int n_miss = 0;
    int press_cnt[4];
    int release_cnt[4];
    int long_cnt[4];
    int r1;

    key_conditioner #(
        .N_KEYS(4),
        .DEB_CYCLES(4),
        .LONG_CYCLES(20),
        .REPEAT_CYCLES(5)
    ) dut (
        .clkI(clkI),
        .rstnI(rstnI),
        .keyI(keyI),
        .levelO(levelO),
        .pressO(pressO),
        .releaseO(releaseO),
        .longO(longO),
        .repeatO(repeatO)
    );

    initial clkI = 1'b0;
    always #5 clkI = ~clkI;

    initial begin
        for (int k = 0; k < 4; k++) begin
            press_cnt[k]   = 0;
            release_cnt[k] = 0;
            long_cnt[k]    = 0;
        end
    end

    always @(negedge clkI) begin
        for (int k = 0; k < 4; k++) begin
            press_cnt[k]   += int'(pressO[k]);
            release_cnt[k] += int'(releaseO[k]);
            long_cnt[k]    += int'(longO[k]);
        end
    end

    task automatic tick();
        @(posedge clkI);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        rstnI = 1'b0;
        keyI  = 4'hF;

        // Reset state
        repeat (3) tick();
        check_vec("rst_level", 32'(levelO), 0);
        check_vec("rst_pulses", 32'({pressO, releaseO, longO, repeatO}), 0);
        rstnI = 1'b1;
        repeat (3) tick();
        check_vec("idle_level", 32'(levelO), 0);

        // Single press on key 0, then clean release
        keyI = 4'b1110;
        repeat (6) tick();
        check_vec("k0_press_early", 32'(pressO), 0);
        tick();
        check_vec("k0_press", 32'(pressO), 32'h1);
        check_vec("k0_level", 32'(levelO), 32'h1);
        tick();
        check_vec("k0_press_once", 32'(pressO), 0);
        keyI = 4'hF;
        repeat (6) tick();
        check_vec("k0_rel_early", 32'(releaseO), 0);
        check_vec("k0_level_hold", 32'(levelO), 32'h1);
        tick();
        check_vec("k0_release", 32'(releaseO), 32'h1);
        check_vec("k0_level_off", 32'(levelO), 0);
        repeat (4) tick();

        // Short bounce on key 1
        keyI = 4'b1101;
        repeat (3) tick();
        keyI = 4'hF;
        repeat (10) tick();
        check_vec("k1_bounce_press", 32'(press_cnt[1]), 0);
        check_vec("k1_bounce_level", 32'(levelO), 0);

        // Long press with auto-repeat on key 2
        keyI = 4'b1011;
        for (int i = 0; i <= 56; i++) begin
            logic rep;
            tick();
            rep = (i == 31) || (i == 36) || (i == 41) || (i == 46);
            check_vec($sformatf("k2_events_e%0d", i),
                      32'({pressO[2], releaseO[2], longO[2], repeatO[2]}),
                      32'({i == 6, i == 53, i == 26, rep}));
            if (i == 46) keyI[2] = 1'b1;
        end
        check_vec("k2_level_off", 32'(levelO), 0);
        repeat (4) tick();

        // Held key 3 with a 2-cycle glitch, then a stable release
        keyI = 4'b0111;
        for (int i = 0; i <= 40; i++) begin
            tick();
            check_vec($sformatf("k3_events_e%0d", i),
                      32'({pressO[3], releaseO[3], longO[3], repeatO[3]}),
                      32'({i == 6, i == 36, i == 28, 1'b0}));
            check_vec($sformatf("k3_level_e%0d", i),
                      32'(levelO[3]), 32'((i >= 6) && (i < 36)));
            if (i == 9)  keyI[3] = 1'b1;
            if (i == 11) keyI[3] = 1'b0;
            if (i == 29) keyI[3] = 1'b1;
        end
        check_vec("k3_release_count", 32'(release_cnt[3]), 1);
        repeat (4) tick();

        // Keys 0 and 3 together
        keyI = 4'b0110;
        repeat (6) tick();
        check_vec("k03_press_early", 32'(pressO), 0);
        tick();
        check_vec("k03_press", 32'(pressO), 32'h9);
        check_vec("k03_level", 32'(levelO), 32'h9);
        tick();
        keyI = 4'hF;
        repeat (6) tick();
        check_vec("k03_rel_early", 32'(releaseO), 0);
        tick();
        check_vec("k03_release", 32'(releaseO), 32'h9);
        check_vec("k03_level_off", 32'(levelO), 0);
        repeat (4) tick();

        // Reset while key 1 is held
        r1   = release_cnt[1];
        keyI = 4'b1101;
        repeat (7) tick();
        check_vec("k1_level_on", 32'(levelO), 32'h2);
        repeat (3) tick();
        #2 rstnI = 1'b0;
        #1;
        check_vec("k1_rst_level_async", 32'(levelO), 0);
        tick();
        tick();
        rstnI = 1'b1;
        repeat (6) tick();
        check_vec("k1_repress_early", 32'(pressO), 0);
        check_vec("k1_repress_level_early", 32'(levelO), 0);
        tick();
        check_vec("k1_repress", 32'(pressO), 32'h2);
        check_vec("k1_repress_level", 32'(levelO), 32'h2);
        check_vec("k1_no_release", 32'(release_cnt[1] - r1), 0);
        keyI = 4'hF;
        repeat (10) tick();
        check_vec("k0_no_long", 32'(long_cnt[0]), 0);
        check_vec("k2_one_long", 32'(long_cnt[2]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
